// File: rtl/int_div_32.sv
// int_div_32: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One operation in flight; quotient and remainder are returned together with a
// fixed latency of OPERAND_SIZE+2 falling edges, counting the accepting edge.
// All state updates on the falling edge of clk to line up with the multiplier.

module int_div_32 #(
  parameter int OPERAND_SIZE = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    signed_div_i,
  input  logic [OPERAND_SIZE-1:0] X,
  input  logic [OPERAND_SIZE-1:0] Y,
  output logic                    busy,
  output logic                    result_rdy,
  output logic [OPERAND_SIZE-1:0] Quotient,
  output logic [OPERAND_SIZE-1:0] Remainder
);

  localparam int W  = OPERAND_SIZE;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIVIDE = 2'd1;
  localparam logic [1:0] S_FIXUP  = 2'd2;

  localparam logic [W-1:0] MIN_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
  localparam logic [CW-1:0] LAST_IT = CW'(W - 1);

  // Control state
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          rdy_q, rdy_d;

  // Captured operation attributes
  logic          signed_q, signed_d;
  logic          q_neg_q, q_neg_d;
  logic          r_neg_q, r_neg_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;
  logic [W-1:0]  x_orig_q, x_orig_d;

  // Datapath: partial remainder, dividend/quotient shift register, divisor
  logic [W-1:0]  prem_q, prem_d;
  logic [W-1:0]  dvd_q, dvd_d;
  logic [W-1:0]  dvs_q, dvs_d;

  // Result registers
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  rem_q, rem_d;

  // Combinational helpers
  logic          x_neg, y_neg;
  logic [W-1:0]  x_mag, y_mag;
  logic [W:0]    trial;
  logic [W:0]    diff;
  logic          fits;
  logic [W-1:0]  quo_fix, rem_fix;

  // Operand magnitudes, trial subtraction and sign fix-up values
  always_comb begin
    x_neg   = signed_div_i & X[W-1];
    y_neg   = signed_div_i & Y[W-1];
    x_mag   = x_neg ? (~X + 1'b1) : X;
    y_mag   = y_neg ? (~Y + 1'b1) : Y;
    // The partial remainder is always below the divisor, so {prem, next bit}
    // fits in W+1 bits and the MSB of the W+1-bit difference is its sign.
    trial   = {prem_q, dvd_q[W-1]};
    diff    = trial - {1'b0, dvs_q};
    fits    = ~diff[W];
    quo_fix = (signed_q & q_neg_q) ? (~dvd_q + 1'b1) : dvd_q;
    rem_fix = (signed_q & r_neg_q) ? (~prem_q + 1'b1) : prem_q;
  end

  // Next-state and datapath update for IDLE / DIVIDE / FIXUP
  always_comb begin
    // NOTE: every signal gets a hold default first so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    rdy_d    = 1'b0;
    signed_d = signed_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;
    x_orig_d = x_orig_q;
    prem_d   = prem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    quo_d    = quo_q;
    rem_d    = rem_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          signed_d = signed_div_i;
          q_neg_d  = X[W-1] ^ Y[W-1];
          r_neg_d  = X[W-1];
          dbz_d    = (Y == '0);
          ovf_d    = signed_div_i && (X == MIN_NEG) && (Y == ALL_ONES);
          x_orig_d = X;
          dvd_d    = x_mag;
          dvs_d    = y_mag;
          prem_d   = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_DIVIDE;
        end
      end

      S_DIVIDE: begin
        prem_d = fits ? diff[W-1:0] : trial[W-1:0];
        dvd_d  = {dvd_q[W-2:0], fits};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_IT) begin
          state_d = S_FIXUP;
        end
      end

      S_FIXUP: begin
        if (dbz_q) begin
          quo_d = ALL_ONES;
          rem_d = x_orig_q;
        end else if (ovf_q) begin
          quo_d = MIN_NEG;
          rem_d = '0;
        end else begin
          quo_d = quo_fix;
          rem_d = rem_fix;
        end
        rdy_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Falling-edge state registers with asynchronous active-high reset
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      rdy_q    <= 1'b0;
      signed_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
      x_orig_q <= '0;
      prem_q   <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      rdy_q    <= rdy_d;
      signed_q <= signed_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
      x_orig_q <= x_orig_d;
      prem_q   <= prem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
    end
  end

  assign busy       = busy_q;
  assign result_rdy = rdy_q;
  assign Quotient   = quo_q;
  assign Remainder  = rem_q;

endmodule

// File: doc/int_div_32.md
Name: int_div_32

Overview:
Iterative radix-2 restoring integer divider for the RV32M DIV/DIVU/REM/REMU instructions. It is the inverse-operation companion to the pipelined multiplier and sits beside it in the execute stage. It accepts one operation at a time and returns quotient and remainder together after a fixed latency. Division-by-zero and signed-overflow results follow the RISC-V spec.

Parameters:
OPERAND_SIZE, 32, width of dividend, divisor, quotient and remainder.

Ports:
clk  input  1  clock; all state updates on falling edge of clk, matching the multiplier timing.
rst  input  1  asynchronous, active-high reset.
start  input  1  request a new division; sampled only when busy=0.
signed_div_i  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU); captured with start.
X  input  OPERAND_SIZE  dividend; captured with start.
Y  input  OPERAND_SIZE  divisor; captured with start.
busy  output  1  high from the accepting edge until the edge that asserts result_rdy.
result_rdy  output  1  one-cycle pulse; Quotient/Remainder valid.
Quotient  output  OPERAND_SIZE  registered quotient, held until the next result.
Remainder  output  OPERAND_SIZE  registered remainder, held until the next result.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, busy=0, result_rdy=0, Quotient=0, Remainder=0, iteration counter=0.
- States:
  - IDLE: on a sampled start=1, go to DIVIDE.
  - DIVIDE: go to FIXUP after OPERAND_SIZE iterations.
  - FIXUP: go to IDLE.
- Capture in IDLE with start=1:
  - Latch signed_div_i.
  - Latch |X| and |Y| (two's-complement magnitude when signed and the operand MSB=1, else raw).
  - Record quotient sign = X[MSB]^Y[MSB] and remainder sign = X[MSB] (signed only).
  - Record div-by-zero flag (Y==0) and overflow flag (signed, X=0x80000000, Y=0xFFFFFFFF).
  - Clear partial remainder and counter. busy=1.
- DIVIDE, one iteration per edge:
  - Shift {partial remainder, dividend} left 1.
  - Trial-subtract the divisor with an (OPERAND_SIZE+1)-bit difference.
  - If non-negative, keep the difference and shift in quotient bit 1; else restore and shift in 0.
  - Counter increments. After iteration OPERAND_SIZE (counter wraps to 0), go to FIXUP.
- FIXUP, one edge:
  - Negate the quotient if its sign flag is set; negate the remainder if its sign flag is set.
  - Register both outputs. result_rdy=1 for this cycle only. busy=0. State=IDLE.
- Special cases override the FIXUP values; latency is unchanged:
  - Div-by-zero: Quotient=all ones, Remainder=original X (signed and unsigned).
  - Overflow: Quotient=0x80000000, Remainder=0.
- Latency: the start-sampling edge is edge 1; the result is registered and result_rdy rises on edge OPERAND_SIZE+2 (34). Fixed for all operands.
- start while busy=1: ignored; the in-flight operation and its operands are unaffected.
- start=1 in the cycle result_rdy=1: accepted, because state is already IDLE, giving back-to-back operation.
- Operand inputs are don't-care except on the accepting edge.
- Reset mid-operation: aborts, no result_rdy pulse; outputs return to 0.
- Outputs hold their last values until overwritten by the next FIXUP or by reset.

Test Plan:
1. Unsigned X=100, Y=7, start 1 cycle -> after 34 edges Quotient=14, Remainder=2, result_rdy exactly 1 cycle, busy high edges 1..33.
2. Signed X=0xFFFFFFF9 (-7), Y=2 -> Quotient=0xFFFFFFFD (-3), Remainder=0xFFFFFFFF (-1). Same operands unsigned -> Quotient=0x7FFFFFFC, Remainder=1.
3. Divide by zero X=5, Y=0, signed and unsigned -> Quotient=0xFFFFFFFF, Remainder=5, latency still 34.
4. Overflow X=0x80000000, Y=0xFFFFFFFF signed -> Quotient=0x80000000, Remainder=0. Unsigned -> Quotient=0, Remainder=0x80000000.
5. start pulsed with X=9, Y=3, then start re-asserted at edge 10 with X=1, Y=1 -> only the first result (Quotient=3, Remainder=0) is produced. Next, start asserted in the result_rdy cycle with X=20, Y=6 -> Quotient=3, Remainder=2 exactly 34 edges later.
6. rst asserted asynchronously at edge 15 of an operation -> immediately busy=0, result_rdy=0, Quotient=0, Remainder=0. No pulse follows. A fresh start after reset completes normally.
